execute_stage: RTL and testbench

- Pipeline EX stage. It consumes the ID/EX register outputs of the decode stage and produces the EX/MEM register.
- Contents: ALU, operand forwarding from MEM/WB, link-address generation, destination-register select, and an iterative multiply/divide unit with HI/LO registers.
- Drives a stall back toward decode/fetch while the multiply/divide unit is busy.

---
 rtl/execute_stage.sv | 224 ++++++++++++++++++++++
 tb/tb_execute_stage.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// Pipeline EX stage: operand forwarding, ALU, link address, destination
// select, iterative multiply/divide with HI/LO, and the EX/MEM register.
module execute_stage #(
    parameter int P_WIDTH       = 32,
    parameter int P_LINK_OFFSET = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [P_WIDTH-1:0] i_data_rs,
    input  logic [P_WIDTH-1:0] i_data_rt,
    input  logic [P_WIDTH-1:0] i_data_imm,
    input  logic [4:0]         i_addr_rs,
    input  logic [4:0]         i_addr_rt,
    input  logic [4:0]         i_addr_rd,
    input  logic [P_WIDTH-1:0] i_addr_pc4,
    input  logic [5:0]         i_con_Ealuop,
    input  logic               i_con_Ealusrc,
    input  logic               i_con_Eregdst,
    input  logic               i_con_Ealupc4,
    input  logic [3:0]         i_con_MW,
    input  logic               i_con_Mregwrite,
    input  logic [4:0]         i_addr_Mreg,
    input  logic [P_WIDTH-1:0] i_data_Mfwd,
    input  logic               i_con_Wregwrite,
    input  logic [4:0]         i_addr_Wreg,
    input  logic [P_WIDTH-1:0] i_data_Wfwd,
    output logic               o_con_stall,
    output logic               o_con_mdbusy,
    output logic [P_WIDTH-1:0] o_data_alu,
    output logic [P_WIDTH-1:0] o_data_store,
    output logic [4:0]         o_addr_dst,
    output logic [3:0]         o_con_MW,
    output logic               o_con_overflow
);
    localparam logic [31:0] LP_LINK = 32'(P_LINK_OFFSET);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_FIX = 2'd2} state_t;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [63:0] r_acc;      // mul: {partial, multiplier}; div: {remainder, quotient}
    logic [31:0] r_opb;      // multiplicand or divisor magnitude
    logic        r_is_div;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_divzero;
    logic [31:0] r_rs_raw;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic [31:0] w_fwd_rs, w_fwd_rt, w_opb, w_alu, w_result, w_sum, w_diff;
    logic [31:0] w_mag_a, w_mag_b, w_hi_next, w_lo_next;
    logic        w_sgn_a, w_sgn_b, w_ovf, w_is_md, w_is_hilo, w_stall;
    logic [4:0]  w_dst;
    logic [32:0] w_madd;
    logic [32:0] w_rem_sh;
    logic [33:0] w_trial;
    logic [63:0] w_mul_next, w_div_next, w_prod;

    // Forward rs/rt from MEM first, then WB; index 0 is never forwarded
    always_comb begin
        w_fwd_rs = i_data_rs;
        w_fwd_rt = i_data_rt;
        if (i_con_Mregwrite && (i_addr_Mreg != 5'd0) && (i_addr_Mreg == i_addr_rs)) begin
            w_fwd_rs = i_data_Mfwd;
        end else if (i_con_Wregwrite && (i_addr_Wreg != 5'd0) && (i_addr_Wreg == i_addr_rs)) begin
            w_fwd_rs = i_data_Wfwd;
        end else begin
            w_fwd_rs = i_data_rs;
        end
        if (i_con_Mregwrite && (i_addr_Mreg != 5'd0) && (i_addr_Mreg == i_addr_rt)) begin
            w_fwd_rt = i_data_Mfwd;
        end else if (i_con_Wregwrite && (i_addr_Wreg != 5'd0) && (i_addr_Wreg == i_addr_rt)) begin
            w_fwd_rt = i_data_Wfwd;
        end else begin
            w_fwd_rt = i_data_rt;
        end
    end

    assign w_opb  = i_con_Ealusrc ? i_data_imm : w_fwd_rt;
    assign w_sum  = w_fwd_rs + w_opb;
    assign w_diff = w_fwd_rs - w_opb;

    // ALU operation select; unknown codes give zero
    always_comb begin
        w_alu = 32'd0;
        case (i_con_Ealuop)
            6'h20, 6'h21: w_alu = w_sum;
            6'h22, 6'h23: w_alu = w_diff;
            6'h24:        w_alu = w_fwd_rs & w_opb;
            6'h25:        w_alu = w_fwd_rs | w_opb;
            6'h26:        w_alu = w_fwd_rs ^ w_opb;
            6'h27:        w_alu = ~(w_fwd_rs | w_opb);
            6'h2A:        w_alu = {31'd0, ($signed(w_fwd_rs) < $signed(w_opb))};
            6'h2B:        w_alu = {31'd0, (w_fwd_rs < w_opb)};
            6'h00:        w_alu = w_opb << i_data_imm[10:6];
            6'h02:        w_alu = w_opb >> i_data_imm[10:6];
            6'h03:        w_alu = $unsigned($signed(w_opb) >>> i_data_imm[10:6]);
            6'h04:        w_alu = w_opb << w_fwd_rs[4:0];
            6'h06:        w_alu = w_opb >> w_fwd_rs[4:0];
            6'h07:        w_alu = $unsigned($signed(w_opb) >>> w_fwd_rs[4:0]);
            6'h0F:        w_alu = {i_data_imm[15:0], 16'h0000};
            6'h10:        w_alu = r_hi;
            6'h12:        w_alu = r_lo;
            default:      w_alu = 32'd0;
        endcase
    end

    // Signed overflow for ADD/SUB only; link results never overflow
    always_comb begin
        w_ovf = 1'b0;
        if (i_con_Ealupc4) begin
            w_ovf = 1'b0;
        end else if (i_con_Ealuop == 6'h20) begin
            w_ovf = (w_fwd_rs[31] == w_opb[31]) && (w_sum[31] != w_fwd_rs[31]);
        end else if (i_con_Ealuop == 6'h22) begin
            w_ovf = (w_fwd_rs[31] != w_opb[31]) && (w_diff[31] != w_fwd_rs[31]);
        end else begin
            w_ovf = 1'b0;
        end
    end

    assign w_result  = i_con_Ealupc4 ? (i_addr_pc4 + LP_LINK) : w_alu;
    assign w_dst     = i_con_Eregdst ? i_addr_rd : (i_con_Ealupc4 ? 5'd31 : i_addr_rt);
    assign w_is_md   = (i_con_Ealuop[5:2] == 4'h6);
    assign w_is_hilo = (i_con_Ealuop == 6'h10) || (i_con_Ealuop == 6'h12);
    assign w_stall   = (r_state != S_IDLE) && (w_is_md || w_is_hilo);

    // Operand magnitudes and signs for the multiply/divide unit
    assign w_sgn_a = ~i_con_Ealuop[0] & w_fwd_rs[31];
    assign w_sgn_b = ~i_con_Ealuop[0] & w_fwd_rt[31];
    assign w_mag_a = w_sgn_a ? (~w_fwd_rs + 32'd1) : w_fwd_rs;
    assign w_mag_b = w_sgn_b ? (~w_fwd_rt + 32'd1) : w_fwd_rt;

    // One shift-add step and one restoring-division step
    assign w_madd     = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opb} : 33'd0);
    assign w_mul_next = {w_madd, r_acc[31:1]};
    assign w_rem_sh   = r_acc[63:31];
    assign w_trial    = {1'b0, w_rem_sh} - {2'b00, r_opb};
    assign w_div_next = w_trial[33] ? {r_acc[62:0], 1'b0} : {w_trial[31:0], r_acc[30:0], 1'b1};

    // Sign fix-up applied when leaving the iterative phase
    always_comb begin
        w_prod    = r_neg_q ? (~r_acc + 64'd1) : r_acc;
        w_hi_next = w_prod[63:32];
        w_lo_next = w_prod[31:0];
        if (r_is_div && r_divzero) begin
            w_hi_next = r_rs_raw;
            w_lo_next = 32'hFFFF_FFFF;
        end else if (r_is_div) begin
            w_hi_next = r_neg_r ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];
            w_lo_next = r_neg_q ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
        end else begin
            w_hi_next = w_prod[63:32];
            w_lo_next = w_prod[31:0];
        end
    end

    // Multiply/divide FSM with HI/LO registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 5'd0;
            r_acc     <= 64'd0;
            r_opb     <= 32'd0;
            r_is_div  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_divzero <= 1'b0;
            r_rs_raw  <= 32'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_is_md) begin
                        r_is_div  <= i_con_Ealuop[1];
                        r_neg_q   <= w_sgn_a ^ w_sgn_b;
                        r_neg_r   <= w_sgn_a;
                        r_divzero <= (w_fwd_rt == 32'd0);
                        r_rs_raw  <= w_fwd_rs;
                        r_opb     <= i_con_Ealuop[1] ? w_mag_b : w_mag_a;
                        r_acc     <= {32'd0, (i_con_Ealuop[1] ? w_mag_a : w_mag_b)};
                        r_cnt     <= 5'd0;
                        r_state   <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_acc <= r_is_div ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_hi    <= w_hi_next;
                    r_lo    <= w_lo_next;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // EX/MEM register; a stall loads a bubble
    always_ff @(posedge i_clk) begin
        if (i_rst || w_stall) begin
            o_data_alu     <= 32'd0;
            o_data_store   <= 32'd0;
            o_addr_dst     <= 5'd0;
            o_con_MW       <= 4'd0;
            o_con_overflow <= 1'b0;
        end else begin
            o_data_alu     <= w_result;
            o_data_store   <= w_fwd_rt;
            o_addr_dst     <= w_dst;
            o_con_MW       <= {i_con_MW[3:1], i_con_MW[0] & ~w_ovf};
            o_con_overflow <= w_ovf;
        end
    end

    assign o_con_stall  = w_stall;
    assign o_con_mdbusy = (r_state != S_IDLE);
endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage.
`timescale 1ns/1ps
module tb_execute_stage;
    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [31:0] i_data_rs, i_data_rt, i_data_imm, i_addr_pc4, i_data_Mfwd, i_data_Wfwd;
    logic [4:0]  i_addr_rs, i_addr_rt, i_addr_rd, i_addr_Mreg, i_addr_Wreg;
    logic [5:0]  i_con_Ealuop;
    logic        i_con_Ealusrc, i_con_Eregdst, i_con_Ealupc4, i_con_Mregwrite, i_con_Wregwrite;
    logic [3:0]  i_con_MW;
    logic        o_con_stall, o_con_mdbusy, o_con_overflow;
    logic [31:0] o_data_alu, o_data_store;
    logic [4:0]  o_addr_dst;
    logic [3:0]  o_con_MW;

    int errors = 0;
    int checks = 0;

    execute_stage dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_data_rs(i_data_rs), .i_data_rt(i_data_rt), .i_data_imm(i_data_imm),
        .i_addr_rs(i_addr_rs), .i_addr_rt(i_addr_rt), .i_addr_rd(i_addr_rd),
        .i_addr_pc4(i_addr_pc4), .i_con_Ealuop(i_con_Ealuop), .i_con_Ealusrc(i_con_Ealusrc),
        .i_con_Eregdst(i_con_Eregdst), .i_con_Ealupc4(i_con_Ealupc4), .i_con_MW(i_con_MW),
        .i_con_Mregwrite(i_con_Mregwrite), .i_addr_Mreg(i_addr_Mreg), .i_data_Mfwd(i_data_Mfwd),
        .i_con_Wregwrite(i_con_Wregwrite), .i_addr_Wreg(i_addr_Wreg), .i_data_Wfwd(i_data_Wfwd),
        .o_con_stall(o_con_stall), .o_con_mdbusy(o_con_mdbusy), .o_data_alu(o_data_alu),
        .o_data_store(o_data_store), .o_addr_dst(o_addr_dst), .o_con_MW(o_con_MW),
        .o_con_overflow(o_con_overflow)
    );

    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_rst = 1'b0;
        i_data_rs = 32'd0; i_data_rt = 32'd0; i_data_imm = 32'd0; i_addr_pc4 = 32'd0;
        i_addr_rs = 5'd1; i_addr_rt = 5'd2; i_addr_rd = 5'd3;
        i_con_Ealuop = 6'h00; i_con_Ealusrc = 1'b0; i_con_Eregdst = 1'b0; i_con_Ealupc4 = 1'b0;
        i_con_MW = 4'd0;
        i_con_Mregwrite = 1'b0; i_addr_Mreg = 5'd0; i_data_Mfwd = 32'd0;
        i_con_Wregwrite = 1'b0; i_addr_Wreg = 5'd0; i_data_Wfwd = 32'd0;
    endtask

    task automatic test_reset();
        clear_inputs();
        i_rst = 1'b1;
        i_data_rs = 32'd1; i_data_rt = 32'd2; i_con_Ealuop = 6'h20;
        i_con_Eregdst = 1'b1; i_con_MW = 4'hF;
        step();
        checks++;
        if ({o_data_alu, o_data_store, o_addr_dst, o_con_MW, o_con_overflow, o_con_mdbusy} !== 75'd0) begin
            errors++;
            $display("FAIL reset: alu=%h store=%h dst=%0d mw=%b ovf=%b busy=%b, required all 0",
                     o_data_alu, o_data_store, o_addr_dst, o_con_MW, o_con_overflow, o_con_mdbusy);
        end
        i_rst = 1'b0;
    endtask

    task automatic test_overflow();
        clear_inputs();
        i_data_rs = 32'h7FFF_FFFF; i_data_rt = 32'd1; i_con_Ealuop = 6'h20;
        i_con_Eregdst = 1'b1; i_addr_rd = 5'd3; i_con_MW = 4'b0001;
        step();
        checks++;
        if ({o_data_alu, o_con_overflow, o_con_MW, o_addr_dst} !== {32'h8000_0000, 1'b1, 4'b0000, 5'd3}) begin
            errors++;
            $display("FAIL add_ovf: alu=%h ovf=%b mw=%b dst=%0d, required 80000000 1 0000 3",
                     o_data_alu, o_con_overflow, o_con_MW, o_addr_dst);
        end
        i_con_Ealuop = 6'h21;
        step();
        checks++;
        if ({o_data_alu, o_con_overflow, o_con_MW} !== {32'h8000_0000, 1'b0, 4'b0001}) begin
            errors++;
            $display("FAIL addu: alu=%h ovf=%b mw=%b, required 80000000 0 0001",
                     o_data_alu, o_con_overflow, o_con_MW);
        end
        i_data_rs = 32'h8000_0000; i_con_Ealuop = 6'h22;
        step();
        checks++;
        if ({o_data_alu, o_con_overflow, o_con_MW} !== {32'h7FFF_FFFF, 1'b1, 4'b0000}) begin
            errors++;
            $display("FAIL sub_ovf: alu=%h ovf=%b mw=%b, required 7fffffff 1 0000",
                     o_data_alu, o_con_overflow, o_con_MW);
        end
    endtask

    task automatic test_forwarding();
        clear_inputs();
        i_addr_rs = 5'd5; i_data_rs = 32'h11; i_addr_rt = 5'd6; i_data_rt = 32'd1;
        i_con_Ealuop = 6'h21;
        i_con_Mregwrite = 1'b1; i_addr_Mreg = 5'd5; i_data_Mfwd = 32'hAA;
        i_con_Wregwrite = 1'b1; i_addr_Wreg = 5'd5; i_data_Wfwd = 32'hBB;
        step();
        checks++;
        if (o_data_alu !== 32'hAB) begin
            errors++;
            $display("FAIL fwd_mem_priority: alu=%h, required 000000ab", o_data_alu);
        end
        i_addr_Mreg = 5'd9;
        step();
        checks++;
        if (o_data_alu !== 32'hBC) begin
            errors++;
            $display("FAIL fwd_wb: alu=%h, required 000000bc", o_data_alu);
        end
        i_addr_rt = 5'd9; i_data_Mfwd = 32'h40;
        step();
        checks++;
        if ({o_data_alu, o_data_store} !== {32'hFB, 32'h40}) begin
            errors++;
            $display("FAIL fwd_rt_store: alu=%h store=%h, required 000000fb 00000040", o_data_alu, o_data_store);
        end
        i_addr_rs = 5'd0; i_data_rs = 32'h10; i_addr_rt = 5'd6; i_data_rt = 32'd1;
        i_addr_Mreg = 5'd0; i_data_Mfwd = 32'h55; i_addr_Wreg = 5'd0;
        step();
        checks++;
        if (o_data_alu !== 32'h11) begin
            errors++;
            $display("FAIL fwd_r0: alu=%h, required 00000011", o_data_alu);
        end
    endtask

    task automatic test_link_shift();
        clear_inputs();
        i_addr_pc4 = 32'h0040_0010; i_con_Ealupc4 = 1'b1; i_con_MW = 4'b0001;
        step();
        checks++;
        if ({o_data_alu, o_addr_dst, o_con_MW} !== {32'h0040_0014, 5'd31, 4'b0001}) begin
            errors++;
            $display("FAIL jal: alu=%h dst=%0d mw=%b, required 00400014 31 0001", o_data_alu, o_addr_dst, o_con_MW);
        end
        clear_inputs();
        i_data_rt = 32'h8000_0000; i_data_imm = 32'h0000_0100; i_con_Ealuop = 6'h03;
        step();
        checks++;
        if ({o_data_alu, o_addr_dst} !== {32'hF800_0000, 5'd2}) begin
            errors++;
            $display("FAIL sra: alu=%h dst=%0d, required f8000000 2", o_data_alu, o_addr_dst);
        end
        i_data_rs = 32'hFFFF_FFFF; i_data_rt = 32'd1; i_con_Ealuop = 6'h2A;
        step();
        checks++;
        if (o_data_alu !== 32'd1) begin
            errors++;
            $display("FAIL slt: alu=%h, required 00000001", o_data_alu);
        end
        i_con_Ealuop = 6'h2B;
        step();
        checks++;
        if (o_data_alu !== 32'd0) begin
            errors++;
            $display("FAIL sltu: alu=%h, required 00000000", o_data_alu);
        end
        i_data_imm = 32'h0000_1234; i_con_Ealuop = 6'h0F;
        step();
        checks++;
        if (o_data_alu !== 32'h1234_0000) begin
            errors++;
            $display("FAIL lui: alu=%h, required 12340000", o_data_alu);
        end
    endtask

    task automatic test_muldiv(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string name);
        int  cnt;
        logic bubble_bad;
        clear_inputs();
        i_data_rs = a; i_data_rt = b; i_con_Ealuop = code;
        step();
        checks++;
        if ({o_data_alu, o_con_MW, o_con_mdbusy} !== {32'd0, 4'd0, 1'b1}) begin
            errors++;
            $display("FAIL %s_issue: alu=%h mw=%b busy=%b, required 0 0000 1", name, o_data_alu, o_con_MW, o_con_mdbusy);
        end
        i_con_Ealuop = 6'h12; i_con_MW = 4'b0001; i_con_Eregdst = 1'b1;
        #1;
        cnt = 0;
        bubble_bad = 1'b0;
        while (o_con_stall && cnt < 100) begin
            step();
            cnt++;
            if (o_data_alu !== 32'd0 || o_con_MW !== 4'd0 || o_addr_dst !== 5'd0) bubble_bad = 1'b1;
        end
        checks++;
        if (cnt !== 33) begin
            errors++;
            $display("FAIL %s_stall_len: cycles=%0d, required 33", name, cnt);
        end
        checks++;
        if (bubble_bad !== 1'b0) begin
            errors++;
            $display("FAIL %s_bubble: non-zero EX/MEM during stall, required zeros", name);
        end
        step();
        checks++;
        if ({o_data_alu, o_con_MW, o_addr_dst} !== {exp_lo, 4'b0001, 5'd3}) begin
            errors++;
            $display("FAIL %s_lo: alu=%h mw=%b dst=%0d, required %h 0001 3", name, o_data_alu, o_con_MW, o_addr_dst, exp_lo);
        end
        i_con_Ealuop = 6'h10;
        #1;
        checks++;
        if (o_con_stall !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle_stall: stall=%b, required 0", name, o_con_stall);
        end
        step();
        checks++;
        if (o_data_alu !== exp_hi) begin
            errors++;
            $display("FAIL %s_hi: alu=%h, required %h", name, o_data_alu, exp_hi);
        end
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        i_data_rs = 32'd7; i_data_rt = 32'd9; i_con_Ealuop = 6'h18;
        step();
        i_con_Ealuop = 6'h20; i_data_rs = 32'd1; i_data_rt = 32'd2;
        i_con_MW = 4'b0001; i_con_Eregdst = 1'b1; i_addr_rd = 5'd4;
        repeat (10) step();
        checks++;
        if ({o_con_mdbusy, o_data_alu, o_addr_dst} !== {1'b1, 32'd3, 5'd4}) begin
            errors++;
            $display("FAIL mid_pre: busy=%b alu=%h dst=%0d, required 1 00000003 4", o_con_mdbusy, o_data_alu, o_addr_dst);
        end
        i_rst = 1'b1;
        step();
        checks++;
        if ({o_data_alu, o_data_store, o_addr_dst, o_con_MW, o_con_overflow, o_con_mdbusy} !== 75'd0) begin
            errors++;
            $display("FAIL mid_reset: alu=%h store=%h dst=%0d mw=%b ovf=%b busy=%b, required all 0",
                     o_data_alu, o_data_store, o_addr_dst, o_con_MW, o_con_overflow, o_con_mdbusy);
        end
        i_rst = 1'b0;
        i_con_Ealuop = 6'h12;
        step();
        checks++;
        if ({o_data_alu, o_addr_dst} !== {32'd0, 5'd4}) begin
            errors++;
            $display("FAIL mid_mflo: alu=%h dst=%0d, required 00000000 4", o_data_alu, o_addr_dst);
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_overflow();
        test_forwarding();
        test_link_shift();
        test_muldiv(6'h18, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult");
        test_muldiv(6'h19, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, "multu");
        test_muldiv(6'h1A, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div");
        test_muldiv(6'h1B, 32'd5, 32'd0, 32'h0000_0005, 32'hFFFF_FFFF, "divu0");
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
